// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life generation sequencer.
// Holds the sequencer state enum, default board size, default rule masks and
// the neighbour offset table indexed by the fetch step k (0 = centre cell).
package life_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WRITE,
        SWAP,
        DONE
    } seq_state_t;

    localparam int BOARD_ROWS = 8;
    localparam int BOARD_COLS = 8;

    // Bit n set: a cell with n live neighbours is born / survives.
    localparam logic [8:0] BIRTH_MASK_DEF   = 9'b000001000;
    localparam logic [8:0] SURVIVE_MASK_DEF = 9'b000001100;

    typedef struct packed {
        logic signed [1:0] drow;
        logic signed [1:0] dcol;
    } nbr_off_t;

    localparam int NBR_COUNT = 9;

    // Entry 0 is the centre cell; 1..8 walk the neighbours row-major.
    localparam nbr_off_t NBR_OFFSET [NBR_COUNT] = '{
        '{drow:  2'sd0, dcol:  2'sd0},
        '{drow: -2'sd1, dcol: -2'sd1},
        '{drow: -2'sd1, dcol:  2'sd0},
        '{drow: -2'sd1, dcol:  2'sd1},
        '{drow:  2'sd0, dcol: -2'sd1},
        '{drow:  2'sd0, dcol:  2'sd1},
        '{drow:  2'sd1, dcol: -2'sd1},
        '{drow:  2'sd1, dcol:  2'sd0},
        '{drow:  2'sd1, dcol:  2'sd1}
    };

endpackage

// File: rtl/life_nbr_addr.sv
// Neighbour address generator: cell (row_i, col_i) plus offset step k_i gives the
// toroidally wrapped board address (row_o, col_o). Purely combinational.
// Ports: row_i/col_i cell coordinates, k_i fetch step 0..8, row_o/col_o wrapped address.
module life_nbr_addr
    import life_pkg::*;
#(
    parameter int  ROWS = BOARD_ROWS,
    parameter int  COLS = BOARD_COLS,
    localparam int RW   = $clog2(ROWS),
    localparam int CW   = $clog2(COLS)
) (
    input  logic [RW-1:0] row_i,
    input  logic [CW-1:0] col_i,
    input  logic [3:0]    k_i,
    output logic [RW-1:0] row_o,
    output logic [CW-1:0] col_o
);

    nbr_off_t off;

    always_comb begin
        off = '0;
        if (k_i < 4'(NBR_COUNT)) begin
            off = NBR_OFFSET[k_i];
        end
        // Power-of-two board: sign-extend the offset and let the add truncate,
        // which is exactly the toroidal wrap.
        row_o = row_i + RW'($signed(off.drow));
        col_o = col_i + CW'($signed(off.dcol));
    end

endmodule

// File: rtl/life_generation_sequencer.sv
// Computes one Game-of-Life generation: for each cell (row-major) reads the cell and
// its 8 toroidal neighbours from the current bank, applies the birth/survive masks,
// writes the result to the shadow bank, then pulses swap and done.
// Ports: start/busy/done handshake, rd_* current-bank read port (1-cycle latency),
// wr_* shadow-bank write port, swap bank exchange pulse, generation counter.
module life_generation_sequencer
    import life_pkg::*;
#(
    parameter int         ROWS         = BOARD_ROWS,
    parameter int         COLS         = BOARD_COLS,
    parameter logic [8:0] BIRTH_MASK   = BIRTH_MASK_DEF,
    parameter logic [8:0] SURVIVE_MASK = SURVIVE_MASK_DEF,
    localparam int        RW           = $clog2(ROWS),
    localparam int        CW           = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [RW-1:0] rd_row,
    output logic [CW-1:0] rd_col,
    input  logic          rd_data,
    output logic          wr_en,
    output logic [RW-1:0] wr_row,
    output logic [CW-1:0] wr_col,
    output logic          wr_data,
    output logic          swap,
    output logic [15:0]   generation
);

    seq_state_t    state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [3:0]    k_q, k_d;
    logic          alive_q, alive_d;
    logic [3:0]    count_q, count_d;
    logic [15:0]   generation_q, generation_d;

    logic          rd_en_q, rd_en_d;
    logic [RW-1:0] rd_row_q, rd_row_d;
    logic [CW-1:0] rd_col_q, rd_col_d;
    logic          wr_en_q, wr_en_d;
    logic [RW-1:0] wr_row_q, wr_row_d;
    logic [CW-1:0] wr_col_q, wr_col_d;
    logic          wr_data_q, wr_data_d;
    logic          swap_q, swap_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic [RW-1:0] nbr_row;
    logic [CW-1:0] nbr_col;

    // Address is generated from the next-state cell/k so the read strobe and
    // its address come out of registers together.
    life_nbr_addr #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_nbr_addr (
        .row_i (row_d),
        .col_i (col_d),
        .k_i   (k_d),
        .row_o (nbr_row),
        .col_o (nbr_col)
    );

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        k_d          = k_q;
        alive_d      = alive_q;
        count_d      = count_q;
        generation_d = generation_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    row_d   = '0;
                    col_d   = '0;
                    k_d     = '0;
                    count_d = '0;
                end
            end
            FETCH: begin
                // Data arriving now belongs to the read issued at step k_q-1.
                if (k_q == 4'd1) begin
                    alive_d = rd_data;
                end else if (k_q != 4'd0) begin
                    count_d = count_q + {3'b000, rd_data};
                end
                if (k_q == 4'd8) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            DRAIN: begin
                count_d = count_q + {3'b000, rd_data};
                state_d = WRITE;
            end
            WRITE: begin
                k_d     = '0;
                count_d = '0;
                state_d = FETCH;
                if (col_q == CW'(COLS - 1)) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                    if (row_q == RW'(ROWS - 1)) begin
                        state_d = SWAP;
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            SWAP: begin
                generation_d = generation_q + 16'd1;
                state_d      = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs: strobes follow the next state, addresses hold
        // whenever their strobe is low.
        rd_en_d   = (state_d == FETCH);
        rd_row_d  = rd_en_d ? nbr_row : rd_row_q;
        rd_col_d  = rd_en_d ? nbr_col : rd_col_q;
        wr_en_d   = (state_d == WRITE);
        wr_row_d  = wr_en_d ? row_d : wr_row_q;
        wr_col_d  = wr_en_d ? col_d : wr_col_q;
        wr_data_d = wr_data_q;
        if (wr_en_d) begin
            wr_data_d = alive_d ? SURVIVE_MASK[count_d] : BIRTH_MASK[count_d];
        end
        swap_d = (state_d == SWAP);
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            k_q          <= '0;
            alive_q      <= 1'b0;
            count_q      <= '0;
            generation_q <= '0;
            rd_en_q      <= 1'b0;
            rd_row_q     <= '0;
            rd_col_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_row_q     <= '0;
            wr_col_q     <= '0;
            wr_data_q    <= 1'b0;
            swap_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            k_q          <= k_d;
            alive_q      <= alive_d;
            count_q      <= count_d;
            generation_q <= generation_d;
            rd_en_q      <= rd_en_d;
            rd_row_q     <= rd_row_d;
            rd_col_q     <= rd_col_d;
            wr_en_q      <= wr_en_d;
            wr_row_q     <= wr_row_d;
            wr_col_q     <= wr_col_d;
            wr_data_q    <= wr_data_d;
            swap_q       <= swap_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_en      = rd_en_q;
    assign rd_row     = rd_row_q;
    assign rd_col     = rd_col_q;
    assign wr_en      = wr_en_q;
    assign wr_row     = wr_row_q;
    assign wr_col     = wr_col_q;
    assign wr_data    = wr_data_q;
    assign swap       = swap_q;
    assign generation = generation_q;

endmodule

// File: tb/tb_life_generation_sequencer.sv
// Testbench for life_generation_sequencer: two-bank 8x8 board model with 1-cycle
// read latency, directed board patterns with hand-computed next generations,
// plus start-ignore, mid-run reset and generation-wrap sequences.
module tb_life_generation_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rd_data = 1'b0;
    logic        busy, done, rd_en, wr_en, wr_data, swap;
    logic [2:0]  rd_row, rd_col, wr_row, wr_col;
    logic [15:0] generation;

    life_generation_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .swap       (swap),
        .generation (generation)
    );

    always #5 clk = ~clk;

    // Board model: bit index = row*8 + col, so byte r of a pattern is row r.
    logic [63:0] bank [2];
    logic        cur = 1'b0;
    logic        load_req = 1'b0;
    logic [63:0] load_pat = '0;

    always @(posedge clk) begin
        if (load_req) bank[cur] <= load_pat;
        if (rd_en) rd_data <= bank[cur][{rd_row, rd_col}];
        if (wr_en) bank[~cur][{wr_row, wr_col}] <= wr_data;
        if (swap) cur <= ~cur;
    end

    int checks = 0;
    int errors = 0;
    int exp_gen = 0;

    // Per-run statistics, indexed by cycle number relative to the start cycle.
    int n_rd, n_wr, n_swap, n_done;
    int first_rd, last_wr, swap_first, swap_last, done_first, done_last, busy_fall;
    logic both_hi, busy_bad;
    logic [5:0] addr2, last_wr_addr;

    localparam logic [63:0] BLINK_H = 64'h00000000_1C000000;
    localparam logic [63:0] BLINK_V = 64'h00000008_08080000;

    typedef struct {
        logic [63:0] init;
        logic [63:0] expv;
        int          gens;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {40'd0, busy, done, rd_en, wr_en, wr_data, swap, rd_row, rd_col,
                   wr_row, wr_col, generation}, 64'd0);
    endtask

    task automatic load_board(input logic [63:0] p);
        @(negedge clk);
        load_pat = p;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Runs ncyc cycles; start is driven high in the listed cycles (-1 = unused),
    // rst is pulsed in cycle rst_at. Cycle 0 is the cycle whose closing edge
    // samples the first start.
    task automatic run(input int ncyc, input int s0, input int s1, input int s2,
                       input int s3, input int rst_at);
        @(negedge clk);
        n_rd = 0; n_wr = 0; n_swap = 0; n_done = 0;
        first_rd = -1; last_wr = -1; swap_first = -1; swap_last = -1;
        done_first = -1; done_last = -1; busy_fall = -1;
        both_hi = 1'b0; busy_bad = 1'b0; addr2 = '0; last_wr_addr = '0;
        start = (s0 == 0) || (s1 == 0) || (s2 == 0) || (s3 == 0);
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            rst = 1'b0;
            if (rd_en) begin
                n_rd++;
                if (first_rd < 0) first_rd = i;
                if (i == 2) addr2 = {rd_row, rd_col};
            end
            if (wr_en) begin
                n_wr++;
                last_wr = i;
                last_wr_addr = {wr_row, wr_col};
            end
            if (rd_en && wr_en) both_hi = 1'b1;
            if (swap) begin
                n_swap++;
                if (swap_first < 0) swap_first = i;
                swap_last = i;
            end
            if (done) begin
                n_done++;
                if (done_first < 0) done_first = i;
                done_last = i;
                if (!busy) busy_bad = 1'b1;
            end else if (done_first >= 0 && busy_fall < 0 && !busy) begin
                busy_fall = i;
            end
            start = (s0 == i) || (s1 == i) || (s2 == i) || (s3 == i);
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                chk_zero("mid_rst_outputs");
            end
        end
        start = 1'b0;
    endtask

    task automatic chk_run_timing();
        chk("rd_en_count", 64'(n_rd), 64'd576);
        chk("wr_en_count", 64'(n_wr), 64'd64);
        chk("first_rd_cycle", 64'(first_rd), 64'd1);
        chk("wrap_rd_addr_k1", 64'(addr2), 64'o77);
        chk("last_wr_cycle", 64'(last_wr), 64'd704);
        chk("last_wr_addr", 64'(last_wr_addr), 64'o77);
        chk("swap_cycle", 64'(swap_first), 64'd705);
        chk("swap_count", 64'(n_swap), 64'd1);
        chk("done_cycle", 64'(done_first), 64'd706);
        chk("busy_fall_cycle", 64'(busy_fall), 64'd707);
        chk("rd_wr_overlap", 64'(both_hi), 64'd0);
        chk("busy_in_done", 64'(busy_bad), 64'd0);
    endtask

    initial begin
        tbl[0] = '{init: BLINK_H,                expv: BLINK_V,                gens: 1};
        tbl[1] = '{init: BLINK_H,                expv: BLINK_H,                gens: 2};
        tbl[2] = '{init: 64'h01000000_00000081,  expv: 64'h81000000_00000081,  gens: 1};
        tbl[3] = '{init: 64'h00003030_00000000,  expv: 64'h00003030_00000000,  gens: 3};
        tbl[4] = '{init: 64'h00000000_00040000,  expv: 64'h0,                  gens: 1};
        tbl[5] = '{init: 64'h0,                  expv: 64'h0,                  gens: 1};

        // Reset state
        #12;
        chk_zero("reset_outputs");
        @(negedge clk);
        rst = 1'b0;

        // Pattern table: blinker, wrap corners, still block, lone cell, empty board
        for (int v = 0; v < 6; v++) begin
            load_board(tbl[v].init);
            for (int g = 0; g < tbl[v].gens; g++) begin
                run(720, 0, -1, -1, -1, -1);
                exp_gen++;
                chk_run_timing();
            end
            chk($sformatf("board_vec%0d", v), bank[cur], tbl[v].expv);
            chk($sformatf("generation_vec%0d", v), 64'(generation), 64'(exp_gen));
        end

        // Starts during FETCH and DONE are ignored; start right after is accepted
        load_board(BLINK_H);
        run(1430, 0, 50, 706, 707, -1);
        exp_gen += 2;
        chk("ign_swap_first", 64'(swap_first), 64'd705);
        chk("ign_swap_second", 64'(swap_last), 64'd1412);
        chk("ign_swap_count", 64'(n_swap), 64'd2);
        chk("ign_done_first", 64'(done_first), 64'd706);
        chk("ign_done_second", 64'(done_last), 64'd1413);
        chk("ign_board", bank[cur], BLINK_H);
        chk("ign_generation", 64'(generation), 64'(exp_gen));

        // Reset mid-run aborts with no swap, then a clean run follows
        load_board(BLINK_H);
        run(800, 0, -1, -1, -1, 300);
        exp_gen = 0;
        chk("rst_swap_count", 64'(n_swap), 64'd0);
        chk("rst_done_count", 64'(n_done), 64'd0);
        chk("rst_generation", 64'(generation), 64'd0);
        run(720, 0, -1, -1, -1, -1);
        exp_gen++;
        chk_run_timing();
        chk("post_rst_board", bank[cur], BLINK_V);
        chk("post_rst_generation", 64'(generation), 64'(exp_gen));

        // Generation counter wraps from FFFF to 0
        @(negedge clk);
        force dut.generation_q = 16'hFFFF;
        @(negedge clk);
        release dut.generation_q;
        run(720, 0, -1, -1, -1, -1);
        chk("wrap_swap_count", 64'(n_swap), 64'd1);
        chk("wrap_swap_cycle", 64'(swap_first), 64'd705);
        chk("wrap_generation", 64'(generation), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
